// File: rtl/epmp_pkg.sv
// Shared EPMP definitions: default widths/depths and the stack operation decode.
package epmp_pkg;

  localparam int EPMP_DATA_W      = 8;
  localparam int EPMP_STACK_DEPTH = 16;

  typedef enum logic [1:0] {
    STK_NOP,
    STK_PUSH,
    STK_POP,
    STK_REPL
  } stack_op_t;

  function automatic stack_op_t decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   decode_op = STK_PUSH;
      2'b01:   decode_op = STK_POP;
      2'b11:   decode_op = STK_REPL;
      default: decode_op = STK_NOP;
    endcase
  endfunction

endpackage

// File: rtl/epmp_stack_mem.sv
// Stack entry storage: one synchronous write port, two asynchronous read ports
// (current top and the entry beneath it). Contents are not reset.
module epmp_stack_mem
  import epmp_pkg::*;
#(
  parameter int   DATA_W = EPMP_DATA_W,
  parameter int   DEPTH  = EPMP_STACK_DEPTH,
  localparam int  AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_l1,
  input  logic [AW-1:0]     raddr_l2,
  output logic [DATA_W-1:0] rdata_l1,
  output logic [DATA_W-1:0] rdata_l2
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_l1 = mem_q[raddr_l1];
  assign rdata_l2 = mem_q[raddr_l2];

endmodule

// File: rtl/epmp_param_stack.sv
// Parametrised EPMP stack: level counter, registered top, sticky error flags.
// Optional high-water mark output enabled by EPMP_STACK_WATERMARK_EN.
module epmp_param_stack
  import epmp_pkg::*;
#(
  parameter int  DATA_W = EPMP_DATA_W,
  parameter int  DEPTH  = EPMP_STACK_DEPTH,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Push,
  input  logic              Pop,
  input  logic [DATA_W-1:0] Din,
  input  logic              Err_Clr,
  output logic [DATA_W-1:0] Top,
  output logic [LVL_W-1:0]  Level,
  output logic              Empty,
  output logic              Full,
  output logic              Overflow,
`ifdef EPMP_STACK_WATERMARK_EN
  output logic [LVL_W-1:0]  Max_Level,
`endif
  output logic              Underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  stack_op_t         op;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] top_q, top_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              set_ovf, set_unf;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [LVL_W-1:0]  lvl_m1, lvl_m2;
  logic [DATA_W-1:0] rd_l2;
  // Top is held in a register, so the top-entry read port has no consumer here.
  logic [DATA_W-1:0] rd_l1_unused;

  assign op     = decode_op(Push, Pop);
  assign lvl_m1 = level_q - LVL_ONE;
  assign lvl_m2 = level_q - LVL_W'(2);
  assign Empty  = (level_q == '0);
  assign Full   = (level_q == LVL_FULL);

  epmp_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk      (clk),
    .we       (mem_we),
    .waddr    (mem_waddr),
    .wdata    (Din),
    .raddr_l1 (lvl_m1[AW-1:0]),
    .raddr_l2 (lvl_m2[AW-1:0]),
    .rdata_l1 (rd_l1_unused),
    .rdata_l2 (rd_l2)
  );

  always_comb begin
    level_d   = level_q;
    top_d     = top_q;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = level_q[AW-1:0];
    case (op)
      STK_PUSH: begin
        if (Full) begin
          set_ovf = 1'b1;
        end else begin
          mem_we  = 1'b1;
          level_d = level_q + LVL_ONE;
          top_d   = Din;
        end
      end
      STK_POP: begin
        if (Empty) begin
          set_unf = 1'b1;
        end else if (level_q == LVL_ONE) begin
          level_d = '0;
          top_d   = '0;
        end else begin
          level_d = lvl_m1;
          top_d   = rd_l2;
        end
      end
      STK_REPL: begin
        mem_we = 1'b1;
        top_d  = Din;
        // Replace on an empty stack degrades to a push but still flags the missing pop.
        if (Empty) begin
          level_d = LVL_ONE;
          set_unf = 1'b1;
        end else begin
          mem_waddr = lvl_m1[AW-1:0];
        end
      end
      default: ;
    endcase
    ovf_d = set_ovf | (ovf_q & ~Err_Clr);
    unf_d = set_unf | (unf_q & ~Err_Clr);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      level_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign Top       = top_q;
  assign Level     = level_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

`ifdef EPMP_STACK_WATERMARK_EN
  logic [LVL_W-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (Err_Clr) begin
      max_d = level_d;
    end else if (level_d > max_q) begin
      max_d = level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign Max_Level = max_q;
`endif

endmodule

// File: tb/tb_epmp_param_stack.sv
// Directed bench for epmp_param_stack at DATA_W=8, DEPTH=4.
module tb_epmp_param_stack;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int LW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          Reset, Push, Pop, Err_Clr;
  logic [DW-1:0] Din;
  logic [DW-1:0] Top;
  logic [LW-1:0] Level;
  logic          Empty, Full, Overflow, Underflow;
`ifdef EPMP_STACK_WATERMARK_EN
  logic [LW-1:0] Max_Level;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  epmp_param_stack #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Push      (Push),
    .Pop       (Pop),
    .Din       (Din),
    .Err_Clr   (Err_Clr),
    .Top       (Top),
    .Level     (Level),
    .Empty     (Empty),
    .Full      (Full),
    .Overflow  (Overflow),
`ifdef EPMP_STACK_WATERMARK_EN
    .Max_Level (Max_Level),
`endif
    .Underflow (Underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] t, input logic [2:0] l,
                           input logic e, input logic f, input logic o, input logic u);
    chk({tag, ".top"},   32'(Top),       32'(t));
    chk({tag, ".level"}, 32'(Level),     32'(l));
    chk({tag, ".empty"}, 32'(Empty),     32'(e));
    chk({tag, ".full"},  32'(Full),      32'(f));
    chk({tag, ".ovf"},   32'(Overflow),  32'(o));
    chk({tag, ".unf"},   32'(Underflow), 32'(u));
  endtask

  // Drive inputs at a falling edge, let one rising edge sample them, return at the next falling edge.
  task automatic cyc(input logic p, input logic q, input logic [7:0] d,
                     input logic c, input logic r);
    Push = p; Pop = q; Din = d; Err_Clr = c; Reset = r;
    @(negedge clk);
    Push = 1'b0; Pop = 1'b0; Err_Clr = 1'b0; Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Push = 1'b0; Pop = 1'b0; Din = '0; Err_Clr = 1'b0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_state("reset", 8'h00, 3'd0, 1, 0, 0, 0);

    cyc(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    chk_state("push11", 8'h11, 3'd1, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    chk_state("push22", 8'h22, 3'd2, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    chk_state("push33", 8'h33, 3'd3, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
    chk_state("push44_full", 8'h44, 3'd4, 0, 1, 0, 0);
    cyc(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    chk_state("push55_ovf", 8'h44, 3'd4, 0, 1, 1, 0);
`ifdef EPMP_STACK_WATERMARK_EN
    chk("max_peak", 32'(Max_Level), 32'd4);
`endif
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("clr_ovf", 8'h44, 3'd4, 0, 1, 0, 0);
`ifdef EPMP_STACK_WATERMARK_EN
    chk("max_after_clr", 32'(Max_Level), 32'd4);
`endif

    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk_state("pop1", 8'h33, 3'd3, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk_state("pop2", 8'h22, 3'd2, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk_state("pop3", 8'h11, 3'd1, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk_state("pop4_empty", 8'h00, 3'd0, 1, 0, 0, 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk_state("pop5_unf", 8'h00, 3'd0, 1, 0, 0, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("clr_unf", 8'h00, 3'd0, 1, 0, 0, 0);

    cyc(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    chk_state("refill2", 8'h22, 3'd2, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    chk_state("replAA", 8'hAA, 3'd2, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk_state("pop_after_repl", 8'h11, 3'd1, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk_state("pop_to_empty", 8'h00, 3'd0, 1, 0, 0, 0);

    cyc(1'b1, 1'b1, 8'h5C, 1'b0, 1'b0);
    chk_state("repl_empty", 8'h5C, 3'd1, 0, 0, 0, 1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk_state("pop_5c", 8'h00, 3'd0, 1, 0, 0, 1);
    cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    chk_state("set_beats_clr", 8'h00, 3'd0, 1, 0, 0, 1);

    cyc(1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
    chk_state("pre_reset", 8'h02, 3'd2, 0, 0, 0, 1);
`ifdef EPMP_STACK_WATERMARK_EN
    chk("max_pre_reset", 32'(Max_Level), 32'd2);
`endif
    cyc(1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
    chk_state("reset_mid", 8'h00, 3'd0, 1, 0, 0, 0);
`ifdef EPMP_STACK_WATERMARK_EN
    chk("max_reset", 32'(Max_Level), 32'd0);
`endif

    cyc(1'b1, 1'b0, 8'h7E, 1'b0, 1'b0);
    chk_state("push_after_reset", 8'h7E, 3'd1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
